// File: rtl/ov5640_ddr_frame_ctrl.sv
// Triple-buffer frame scheduler between the OV5640 capture path and DDR.
// Hands out write buffers, publishes complete frames and grants the newest one to the PCIe reader.
module ov5640_ddr_frame_ctrl #(
  parameter int                 ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR    = 32'h0000_0000,
  parameter logic [ADDR_W-1:0]  FRAME_STRIDE = 32'h0080_0000,
  parameter int                 FRAME_BEATS  = 307200,
  parameter int                 CNT_W        = 20
) (
  input  logic              axi_clk,
  input  logic              axi_rst_n,
  input  logic              wr_frame_start,
  input  logic              wr_data_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_base_addr,
  output logic [1:0]        wr_frame_idx,
  output logic              wr_frame_done,
  input  logic              rd_req,
  output logic              rd_grant,
  output logic [ADDR_W-1:0] rd_base_addr,
  output logic [1:0]        rd_frame_idx,
  input  logic              rd_release,
  output logic              rd_busy,
  output logic              frame_new,
  output logic [15:0]       drop_cnt
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WRITE = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_BEATS - 1);

  state_t              state_q;
  logic [1:0]          w_idx_q, latest_q, r_idx_q;
  logic                latest_vld_q, rd_busy_q, frame_new_q;
  logic                wr_done_q, rd_grant_q;
  logic [CNT_W-1:0]    beat_cnt_q;
  logic [15:0]         drop_cnt_q;
  logic [ADDR_W-1:0]   wr_base_q, rd_base_q;

  logic                complete_d, grant_d;
  logic [1:0]          alloc_idx_d;

  // Lowest buffer index not excluded by either of two optional holders.
  function automatic logic [1:0] pick_free(input logic [1:0] a, input logic a_en,
                                           input logic [1:0] b, input logic b_en);
    logic [1:0] k;
    k = 2'd2;
    for (int i = 2; i >= 0; i--) begin
      if (!((a_en && a == 2'(i)) || (b_en && b == 2'(i)))) k = 2'(i);
    end
    return k;
  endfunction

  function automatic logic [ADDR_W-1:0] buf_base(input logic [1:0] k);
    return BASE_ADDR + ADDR_W'(k) * FRAME_STRIDE;
  endfunction

  // A buffer granted this very cycle is also excluded so writer and reader can never collide.
  always_comb begin
    complete_d  = (state_q == S_WRITE) && wr_data_valid && (beat_cnt_q == LAST_BEAT);
    grant_d     = rd_req && !rd_busy_q && latest_vld_q;
    alloc_idx_d = pick_free(complete_d ? w_idx_q : latest_q, latest_vld_q || complete_d,
                            grant_d ? latest_q : r_idx_q, rd_busy_q || grant_d);
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_rst_n) begin
      state_q      <= S_IDLE;
      w_idx_q      <= 2'd0;
      latest_q     <= 2'd0;
      latest_vld_q <= 1'b0;
      r_idx_q      <= 2'd0;
      rd_busy_q    <= 1'b0;
      frame_new_q  <= 1'b0;
      wr_done_q    <= 1'b0;
      rd_grant_q   <= 1'b0;
      beat_cnt_q   <= '0;
      drop_cnt_q   <= 16'd0;
      wr_base_q    <= BASE_ADDR;
      rd_base_q    <= BASE_ADDR;
    end else begin
      wr_done_q  <= complete_d;
      rd_grant_q <= grant_d;
      case (state_q)
        S_IDLE: begin
          if (wr_frame_start) begin
            state_q    <= S_WRITE;
            w_idx_q    <= alloc_idx_d;
            wr_base_q  <= buf_base(alloc_idx_d);
            beat_cnt_q <= '0;
          end
        end
        S_WRITE: begin
          if (complete_d) begin
            latest_q     <= w_idx_q;
            latest_vld_q <= 1'b1;
          end
          if (wr_frame_start) begin
            w_idx_q    <= alloc_idx_d;
            wr_base_q  <= buf_base(alloc_idx_d);
            beat_cnt_q <= '0;
            if (!complete_d && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
          end else if (complete_d) begin
            state_q <= S_IDLE;
          end else if (wr_data_valid) begin
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // A frame completing alongside a grant is itself still ungranted.
      if (complete_d) frame_new_q <= 1'b1;
      else if (grant_d) frame_new_q <= 1'b0;
      if (grant_d) begin
        r_idx_q   <= latest_q;
        rd_base_q <= buf_base(latest_q);
        rd_busy_q <= 1'b1;
      end else if (rd_release) begin
        rd_busy_q <= 1'b0;
      end
    end
  end

  assign wr_en         = (state_q == S_WRITE);
  assign wr_base_addr  = wr_base_q;
  assign wr_frame_idx  = w_idx_q;
  assign wr_frame_done = wr_done_q;
  assign rd_grant      = rd_grant_q;
  assign rd_base_addr  = rd_base_q;
  assign rd_frame_idx  = r_idx_q;
  assign rd_busy       = rd_busy_q;
  assign frame_new     = frame_new_q;
  assign drop_cnt      = drop_cnt_q;

endmodule
